// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolling 16x16 pipe playfield for the flappy-bird game.
// In RUN the playfield moves one column toward the exit edge every TICK_DIV
// clocks; a new pipe column with an LFSR-placed gap enters every PIPE_SPACING
// scroll steps.  Pipes crossing the bird column are counted as the score.
// A fail pulse from the collision checker freezes everything until Reset.
//
// Handshake: there is no valid/ready pair.  start is a level sampled only in
// IDLE; freeze is a single-cycle event honoured only in RUN; step is a
// registered one-cycle strobe that marks every new pipes/score value.
module pipe_scroller #(
    parameter int         TICK_DIV     = 4,
    parameter int         PIPE_SPACING = 4,
    parameter int         GAP_HEIGHT   = 4,
    parameter int         BIRD_COL     = 12,
    parameter logic [7:0] LFSR_SEED    = 8'h01
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              start,
    input  logic              freeze,
    output logic [15:0][15:0] pipes,
    output logic [7:0]        score,
    output logic              step,
    output logic              running,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPAWN_RELOAD = SW'(PIPE_SPACING - 1);
    localparam int GAP_LIMIT = 16 - GAP_HEIGHT;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] spawn_cnt;
    logic [7:0]    lfsr;
    logic          do_step;
    logic [4:0]    gap_top;
    logic [15:0]   pipe_col;
    logic [15:0]   new_col;
    logic          bird_hit;

    // A scroll step needs the last tick of the period and no same-cycle fail.
    assign do_step = (state == S_RUN) && !freeze && (tick_cnt == TICK_LAST);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; FROZEN is only left through Reset.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start)  state_nx = S_RUN;
            S_RUN:    if (freeze) state_nx = S_FROZEN;
            S_FROZEN: state_nx = S_FROZEN;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so no input reaches them.
    always_comb begin
        running   = (state == S_RUN);
        state_dbg = state;
    end

    // New column: gap top from the low LFSR nibble, folded back into range.
    always_comb begin
        gap_top = {1'b0, lfsr[3:0]};
        if (gap_top > 5'(GAP_LIMIT)) begin
            gap_top = gap_top - 5'(GAP_LIMIT);
        end
        for (int r = 0; r < 16; r++) begin
            pipe_col[r] = !((5'(r) >= gap_top) && (5'(r) < gap_top + 5'(GAP_HEIGHT)));
        end
        new_col = (spawn_cnt == '0) ? pipe_col : 16'h0000;
    end

    // Any pipe cell in the bird column before the shift scores a point.
    always_comb begin
        bird_hit = 1'b0;
        for (int r = 0; r < 16; r++) begin
            bird_hit = bird_hit | pipes[r][BIRD_COL];
        end
    end

    // Tick divider, playfield shift, spawn spacing, LFSR and score.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pipes     <= '0;
            score     <= 8'd0;
            step      <= 1'b0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            step <= do_step;
            if (state == S_IDLE && start) begin
                tick_cnt <= '0;
            end else if (state == S_RUN && !freeze) begin
                tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
            end
            if (do_step) begin
                for (int r = 0; r < 16; r++) begin
                    pipes[r] <= {pipes[r][14:0], new_col[r]};
                end
                spawn_cnt <= (spawn_cnt == '0) ? SPAWN_RELOAD : spawn_cnt - SW'(1);
                lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                if (bird_hit && score != 8'hFF) begin
                    score <= score + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Testbench for pipe_scroller: directed scenarios from the game rules, a
// randomized run against a column-queue reference model, a gap-wrap instance
// and a score-saturation instance.
module tb_pipe_scroller;

    localparam int TD = 4;
    localparam int PS = 4;
    localparam int G  = 4;
    localparam int BC = 12;

    // ---------------- clock / reset ----------------
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic start = 1'b0;
    logic freeze = 1'b0;
    logic frz_aux = 1'b0;

    always #5 Clock = ~Clock;

    logic [15:0][15:0] pipes0, pipes1, pipes2;
    logic [7:0]        score0, score1, score2;
    logic              step0, step1, step2;
    logic              running0, running1, running2;
    logic [1:0]        dbg0, dbg1, dbg2;

    pipe_scroller dut0 (
        .Clock(Clock), .Reset(Reset), .start(start), .freeze(freeze),
        .pipes(pipes0), .score(score0), .step(step0), .running(running0),
        .state_dbg(dbg0)
    );

    pipe_scroller #(.LFSR_SEED(8'h0F), .GAP_HEIGHT(4)) dut1 (
        .Clock(Clock), .Reset(Reset), .start(start), .freeze(frz_aux),
        .pipes(pipes1), .score(score1), .step(step1), .running(running1),
        .state_dbg(dbg1)
    );

    pipe_scroller #(.TICK_DIV(2), .PIPE_SPACING(1)) dut2 (
        .Clock(Clock), .Reset(Reset), .start(start), .freeze(frz_aux),
        .pipes(pipes2), .score(score2), .step(step2), .running(running2),
        .state_dbg(dbg2)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // ---------------- reference model (dut0 defaults) ----------------
    // Playfield kept as a list of columns, each a 16-bit vector indexed by row.
    int          m_mode;   // 0 idle, 1 run, 2 frozen
    int          m_tick;
    int          m_spawn;
    int          m_score;
    logic        m_step;
    logic [7:0]  m_lfsr;
    logic [15:0] m_col [16];

    function automatic logic [15:0] pipe_column(input logic [7:0] l, input int gap);
        logic [15:0] v;
        int gt;
        gt = int'(l) % 16;
        if (gt > 16 - gap) gt = gt - (16 - gap);
        for (int r = 0; r < 16; r++) v[r] = (r >= gt && r < gt + gap) ? 1'b0 : 1'b1;
        return v;
    endfunction

    function automatic logic [15:0][15:0] exp_image();
        logic [15:0][15:0] e;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) e[r][c] = m_col[c][r];
        return e;
    endfunction

    function automatic logic [15:0][15:0] image_with(input int c, input logic [15:0] v);
        logic [15:0][15:0] e;
        e = '0;
        for (int r = 0; r < 16; r++) e[r][c] = v[r];
        return e;
    endfunction

    function automatic logic [15:0] column_of(input logic [15:0][15:0] p, input int c);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = p[r][c];
        return v;
    endfunction

    task automatic model_edge(input logic s, input logic f, input logic r);
        logic bird;
        logic fb;
        if (r) begin
            m_mode = 0; m_tick = 0; m_spawn = 0; m_score = 0; m_step = 1'b0;
            m_lfsr = 8'h01;
            for (int c = 0; c < 16; c++) m_col[c] = 16'h0000;
        end else begin
            m_step = 1'b0;
            if (m_mode == 0) begin
                if (s) begin m_mode = 1; m_tick = 0; end
            end else if (m_mode == 1) begin
                if (f) begin
                    m_mode = 2;
                end else if (m_tick == TD - 1) begin
                    bird = (m_col[BC] != 16'h0000);
                    for (int c = 15; c > 0; c--) m_col[c] = m_col[c-1];
                    m_col[0] = (m_spawn == 0) ? pipe_column(m_lfsr, G) : 16'h0000;
                    m_spawn = (m_spawn == 0) ? PS - 1 : m_spawn - 1;
                    fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
                    m_lfsr = {m_lfsr[6:0], fb};
                    if (bird && m_score < 255) m_score = m_score + 1;
                    m_step = 1'b1;
                    m_tick = 0;
                end else begin
                    m_tick = m_tick + 1;
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic s, input logic f, input logic r);
        start = s; freeze = f; Reset = r;
        @(posedge Clock);
        model_edge(s, f, r);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (pipes0 !== '0) begin failures++; $display("FAIL reset_pipes got %h expected 0", pipes0); end
        checks++;
        if (score0 !== 8'd0) begin failures++; $display("FAIL reset_score got %0d expected 0", score0); end
        checks++;
        if (step0 !== 1'b0 || running0 !== 1'b0) begin
            failures++; $display("FAIL reset_flags step=%b running=%b expected 0 0", step0, running0);
        end
        checks++;
        if (dbg0 !== 2'd0) begin failures++; $display("FAIL reset_state got %0d expected 0", dbg0); end
    endtask

    task automatic test_first_spawn();
        drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (running0 !== 1'b1 || step0 !== 1'b0) begin
            failures++; $display("FAIL start_running running=%b step=%b expected 1 0", running0, step0);
        end
        for (int i = 1; i <= 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (step0 !== 1'b0) begin failures++; $display("FAIL early_step edge %0d got %b expected 0", i, step0); end
        end
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (step0 !== 1'b1 || running0 !== 1'b1) begin
            failures++; $display("FAIL first_step step=%b running=%b expected 1 1", step0, running0);
        end
        checks++;
        if (pipes0 !== image_with(0, 16'hFFE1)) begin
            failures++; $display("FAIL first_column got %h expected %h", pipes0, image_with(0, 16'hFFE1));
        end
        checks++;
        if (score0 !== 8'd0) begin failures++; $display("FAIL first_score got %0d expected 0", score0); end
        drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (step0 !== 1'b0) begin failures++; $display("FAIL step_width got %b expected 0", step0); end
    endtask

    task automatic test_scroll_spacing();
        // Already one cycle past step 1; finish the remaining 3 cycles first.
        for (int k = 2; k <= 5; k++) begin
            repeat ((k == 2) ? 3 : 4) drive_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (step0 !== 1'b1) begin failures++; $display("FAIL scroll_step k=%0d got %b expected 1", k, step0); end
            checks++;
            if (k < 5 && pipes0 !== image_with(k - 1, 16'hFFE1)) begin
                failures++; $display("FAIL scroll_image k=%0d got %h expected %h", k, pipes0, image_with(k - 1, 16'hFFE1));
            end else if (k == 5 && pipes0 !== (image_with(4, 16'hFFE1) | image_with(0, 16'hFFE1))) begin
                failures++; $display("FAIL second_spawn got %h expected %h", pipes0,
                                     image_with(4, 16'hFFE1) | image_with(0, 16'hFFE1));
            end
        end
    endtask

    task automatic test_score();
        for (int k = 6; k <= 17; k++) begin
            repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
            if (k == 13 || k == 14 || k == 17) begin
                checks++;
                if (score0 !== ((k == 13) ? 8'd0 : 8'd1)) begin
                    failures++; $display("FAIL score k=%0d got %0d expected %0d", k, score0, (k == 13) ? 0 : 1);
                end
            end
            if (k == 16 || k == 17) begin
                checks++;
                if (column_of(pipes0, 15) !== ((k == 16) ? 16'hFFE1 : 16'h0000)) begin
                    failures++; $display("FAIL exit_column k=%0d got %h expected %h", k, column_of(pipes0, 15),
                                         (k == 16) ? 16'hFFE1 : 16'h0000);
                end
            end
        end
    endtask

    task automatic test_freeze();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (8) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (pipes0 !== image_with(1, 16'hFFE1)) begin
            failures++; $display("FAIL freeze_pre got %h expected %h", pipes0, image_with(1, 16'hFFE1));
        end
        repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (step0 !== 1'b0 || running0 !== 1'b0 || dbg0 !== 2'd2) begin
            failures++; $display("FAIL freeze_flags step=%b running=%b state=%0d expected 0 0 2", step0, running0, dbg0);
        end
        for (int i = 0; i < 24; i++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (pipes0 !== image_with(1, 16'hFFE1) || step0 !== 1'b0 || running0 !== 1'b0 || score0 !== 8'd0) begin
                failures++; $display("FAIL freeze_hold cycle %0d pipes=%h step=%b running=%b score=%0d", i, pipes0,
                                     step0, running0, score0);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (24) drive_cycle(1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (pipes0 !== '0 || score0 !== 8'd0 || running0 !== 1'b0) begin
            failures++; $display("FAIL mid_reset pipes=%h score=%0d running=%b expected 0 0 0", pipes0, score0, running0);
        end
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (pipes0 !== image_with(0, 16'hFFE1) || step0 !== 1'b1 || score0 !== 8'd0) begin
            failures++; $display("FAIL restart pipes=%h step=%b score=%0d expected %h 1 0", pipes0, step0, score0,
                                 image_with(0, 16'hFFE1));
        end
    endtask

    task automatic test_gap_wrap();
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (pipes1 !== image_with(0, 16'hFF87) || step1 !== 1'b1) begin
            failures++; $display("FAIL gap_wrap pipes=%h step=%b expected %h 1", pipes1, step1, image_with(0, 16'hFF87));
        end
    endtask

    task automatic test_random();
        logic s, f, r;
        drive_cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            s = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 199) == 0);
            r = (m_mode == 2) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 799) == 0);
            drive_cycle(s, f, r);
            checks++;
            if (pipes0 !== exp_image()) begin
                failures++; $display("FAIL random_pipes cycle %0d got %h expected %h", i, pipes0, exp_image());
            end
            checks++;
            if (score0 !== 8'(m_score)) begin
                failures++; $display("FAIL random_score cycle %0d got %0d expected %0d", i, score0, m_score);
            end
            checks++;
            if (step0 !== m_step) begin
                failures++; $display("FAIL random_step cycle %0d got %b expected %b", i, step0, m_step);
            end
            checks++;
            if (running0 !== (m_mode == 1)) begin
                failures++; $display("FAIL random_running cycle %0d got %b expected %b", i, running0, m_mode == 1);
            end
        end
    endtask

    task automatic test_saturation();
        int nsteps;
        logic [7:0] e;
        exp_q = {};
        for (int k = 1; k <= 320; k++) exp_q.push_back((k < 14) ? 8'd0 : ((k - 13 > 255) ? 8'd255 : 8'(k - 13)));
        nsteps = 0;
        drive_cycle(1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            if (step2 === 1'b1 && exp_q.size() > 0) begin
                nsteps++;
                e = exp_q.pop_front();
                checks++;
                if (score2 !== e) begin
                    failures++; $display("FAIL sat_score step %0d got %0d expected %0d", nsteps, score2, e);
                end
            end
        end
        checks++;
        if (nsteps < 290 || score2 !== 8'd255) begin
            failures++; $display("FAIL sat_final steps=%0d score=%0d expected >=290 255", nsteps, score2);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_spawn();
        test_scroll_spacing();
        test_score();
        test_freeze();
        test_reset_mid_run();
        test_gap_wrap();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
